// File: rtl/reg_bus_master_pkg.sv
// Shared definitions for the register bus initiator: bus timing defaults,
// the phase state encoding and the address space size of the main register bus.
package reg_bus_master_pkg;

  // Default bus phase lengths, in clock cycles
  localparam int REG_BUS_SETUP  = 1;
  localparam int REG_BUS_STROBE = 2;
  localparam int REG_BUS_HOLD   = 1;

  // Number of addressable registers on the main register bus
  localparam int MAIN_REG_ADDR_SPACE = 256;

  // Bus cycle phases
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Width of the phase counter: it is loaded with (phase length - 1),
  // so it needs enough bits for the longest phase minus one.
  function automatic int phase_cnt_width(input int s, input int t, input int h);
    int m;
    m = s;
    if (t > m) m = t;
    if (h > m) m = h;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/reg_bus_phase_timer.sv
// Loadable down-counter with a terminal-count flag. The owner loads
// (phase length - 1) when entering a phase; o_tc is high in the last
// cycle of that phase.
module reg_bus_phase_timer #(
  parameter int CNT_W = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  // Load takes priority over counting; the counter parks at zero
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/reg_bus_master.sv
// Clocked initiator for the asynchronous main register bus. Converts
// single-beat read/write requests into phased en/rd/wr bus cycles
// (SETUP, STROBE, HOLD) and reports completion on a one-cycle response pulse.
//
// Request handshake: a request transfers on a rising edge where
// i_req_valid and o_req_ready are both high. o_req_ready is high only while
// the master is idle and out of reset; the request fields are captured at
// that edge and need not be held afterwards. o_rsp_valid pulses once per
// transfer, in the first HOLD cycle, and is not back-pressured.
module reg_bus_master
  import reg_bus_master_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int SETUP_CYCLES  = REG_BUS_SETUP,
  parameter int STROBE_CYCLES = REG_BUS_STROBE,
  parameter int HOLD_CYCLES   = REG_BUS_HOLD
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [1:0]            i_req_be,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_bus_en,
  output logic                  o_bus_rd,
  output logic                  o_bus_wr,
  output logic [1:0]            o_bus_be,
  output logic [ADDR_WIDTH-1:0] o_bus_addr,
  inout  wire  [DATA_WIDTH-1:0] io_bus_data,
  output state_t                o_dbg_state,
  output logic                  o_dbg_bus_oe
);

  localparam int CNT_W = phase_cnt_width(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(HOLD_CYCLES - 1);

  state_t                r_state;
  logic                  r_ready;
  logic                  r_write;
  logic                  r_en;
  logic                  r_rd;
  logic                  r_wr;
  logic                  r_oe;
  logic                  r_rsp_valid;
  logic [1:0]            r_be;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_accept;
  logic                  w_tc;
  logic                  w_load;
  logic [CNT_W-1:0]      w_load_val;

  // Ready is forced low combinationally while reset is asserted
  assign o_req_ready = r_ready & ~i_reset;
  assign w_accept    = i_req_valid & o_req_ready;

  // Phase timer reload: on entry to each phase, load its length minus one
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        w_load     = w_accept;
        w_load_val = LD_SETUP;
      end
      ST_SETUP: begin
        w_load     = w_tc;
        w_load_val = LD_STROBE;
      end
      ST_STROBE: begin
        w_load     = w_tc;
        w_load_val = LD_HOLD;
      end
      default: begin
        w_load     = 1'b0;
        w_load_val = '0;
      end
    endcase
  end

  reg_bus_phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  // Bus cycle sequencer with all bus-facing outputs registered
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b0;
      r_write     <= 1'b0;
      r_en        <= 1'b0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_oe        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_be        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_state <= ST_SETUP;
            r_ready <= 1'b0;
            r_write <= i_req_write;
            r_addr  <= i_req_addr;
            r_be    <= i_req_be;
            r_wdata <= i_req_wdata;
            r_en    <= 1'b1;
            r_oe    <= i_req_write;
          end
        end
        ST_SETUP: begin
          if (w_tc) begin
            r_state <= ST_STROBE;
            r_rd    <= ~r_write;
            r_wr    <= r_write;
          end
        end
        ST_STROBE: begin
          if (w_tc) begin
            r_state     <= ST_HOLD;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_rsp_valid <= 1'b1;
            // Read data is sampled at the edge that closes the strobe
            if (!r_write) begin
              r_rdata <= io_bus_data;
            end
          end
        end
        ST_HOLD: begin
          if (w_tc) begin
            r_state <= ST_IDLE;
            r_en    <= 1'b0;
            r_oe    <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The shared data bus is driven only for the duration of a write cycle
  assign io_bus_data = r_oe ? r_wdata : {DATA_WIDTH{1'bz}};

  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_rdata  = r_rdata;
  assign o_bus_en     = r_en;
  assign o_bus_rd     = r_rd;
  assign o_bus_wr     = r_wr;
  assign o_bus_be     = r_be;
  assign o_bus_addr   = r_addr;
  assign o_dbg_state  = r_state;
  assign o_dbg_bus_oe = r_oe;

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: two instances (default timing and S=2/T=3/H=2),
// each attached to a behavioural Registers responder, checked cycle by cycle
// against a transaction-level timing and register-content model.
`timescale 1ns/1ps
module tb_reg_bus_master;
  import reg_bus_master_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- shared request fields ----------------
  logic        req_valid_a, req_valid_b;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [1:0]  req_be;
  logic [15:0] req_wdata;

  // ---------------- instance A (defaults) ----------------
  logic        ready_a, rv_a, en_a, rd_a, wr_a, oe_a;
  logic [15:0] rdata_a;
  logic [1:0]  be_a;
  logic [7:0]  addr_a;
  state_t      st_a;
  wire  [15:0] bus_a;

  reg_bus_master u_dut_a (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req_valid (req_valid_a),
    .o_req_ready (ready_a),
    .i_req_write (req_write),
    .i_req_addr  (req_addr),
    .i_req_be    (req_be),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rv_a),
    .o_rsp_rdata (rdata_a),
    .o_bus_en    (en_a),
    .o_bus_rd    (rd_a),
    .o_bus_wr    (wr_a),
    .o_bus_be    (be_a),
    .o_bus_addr  (addr_a),
    .io_bus_data (bus_a),
    .o_dbg_state (st_a),
    .o_dbg_bus_oe(oe_a)
  );

  // ---------------- instance B (S=2, T=3, H=2) ----------------
  logic        ready_b, rv_b, en_b, rd_b, wr_b, oe_b;
  logic [15:0] rdata_b;
  logic [1:0]  be_b;
  logic [7:0]  addr_b;
  state_t      st_b;
  wire  [15:0] bus_b;

  reg_bus_master #(
    .SETUP_CYCLES (2),
    .STROBE_CYCLES(3),
    .HOLD_CYCLES  (2)
  ) u_dut_b (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req_valid (req_valid_b),
    .o_req_ready (ready_b),
    .i_req_write (req_write),
    .i_req_addr  (req_addr),
    .i_req_be    (req_be),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rv_b),
    .o_rsp_rdata (rdata_b),
    .o_bus_en    (en_b),
    .o_bus_rd    (rd_b),
    .o_bus_wr    (wr_b),
    .o_bus_be    (be_b),
    .o_bus_addr  (addr_b),
    .io_bus_data (bus_b),
    .o_dbg_state (st_b),
    .o_dbg_bus_oe(oe_b)
  );

  // ---------------- Registers responders ----------------
  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];

  assign bus_a = (en_a && rd_a) ? mem_a[addr_a] : 16'bz;
  assign bus_b = (en_b && rd_b) ? mem_b[addr_b] : 16'bz;

  always @(negedge wr_a) begin
    if (en_a) begin
      if (be_a[0]) mem_a[addr_a][7:0]  = bus_a[7:0];
      if (be_a[1]) mem_a[addr_a][15:8] = bus_a[15:8];
    end
  end

  always @(negedge wr_b) begin
    if (en_b) begin
      if (be_b[0]) mem_b[addr_b][7:0]  = bus_b[7:0];
      if (be_b[1]) mem_b[addr_b][15:8] = bus_b[15:8];
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [15:0] ref_mem [2][256];
  logic [15:0] last_rd [2];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {en, rd, wr, oe, rsp_valid, ready}
  function automatic logic [5:0] ctl_of(input int s);
    if (s != 0) return {en_b, rd_b, wr_b, oe_b, rv_b, ready_b};
    return {en_a, rd_a, wr_a, oe_a, rv_a, ready_a};
  endfunction

  function automatic logic [9:0] ab_of(input int s);
    if (s != 0) return {addr_b, be_b};
    return {addr_a, be_a};
  endfunction

  function automatic logic [15:0] bus_of(input int s);
    if (s != 0) return bus_b;
    return bus_a;
  endfunction

  function automatic logic [15:0] rdata_of(input int s);
    if (s != 0) return rdata_b;
    return rdata_a;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input int s, input logic v);
    if (s != 0) req_valid_b = v;
    else        req_valid_a = v;
  endtask

  // Issue one request on instance s and follow it to the idle cycle after HOLD.
  // Returns in that idle cycle (ready high) so the next request can follow
  // immediately.
  task automatic run_txn(input int s, input logic w, input logic [7:0] a,
                         input logic [1:0] be, input logic [15:0] d, input logic hold);
    int sc   = (s != 0) ? 2 : 1;
    int tc   = (s != 0) ? 3 : 2;
    int hc   = (s != 0) ? 2 : 1;
    int busy = sc + tc + hc;
    int n    = 0;
    logic [15:0] exp_rd;
    logic [5:0]  exp_ctl;
    while (!ctl_of(s)[0] && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("ready_wait_i%0d", s), 32'(ctl_of(s)[0]), 32'd1);
    if (!ctl_of(s)[0]) return;
    // Model: registers merge written bytes; response data only changes on reads
    if (w) begin
      if (be[0]) ref_mem[s][a][7:0]  = d[7:0];
      if (be[1]) ref_mem[s][a][15:8] = d[15:8];
      exp_rd = last_rd[s];
    end else begin
      exp_rd = ref_mem[s][a];
    end
    last_rd[s] = exp_rd;
    req_write = w;
    req_addr  = a;
    req_be    = be;
    req_wdata = d;
    set_valid(s, 1'b1);
    tick();
    if (!hold) set_valid(s, 1'b0);
    for (int k = 1; k <= busy + 1; k++) begin
      exp_ctl = {k <= busy,
                 !w && (k > sc) && (k <= sc + tc),
                 w && (k > sc) && (k <= sc + tc),
                 w && (k <= busy),
                 k == sc + tc + 1,
                 k == busy + 1};
      check($sformatf("ctl_i%0d_c%0d", s, k), 32'(ctl_of(s)), 32'(exp_ctl));
      if (k <= busy)
        check($sformatf("addr_be_i%0d_c%0d", s, k), 32'(ab_of(s)), 32'({a, be}));
      if (w && k <= busy)
        check($sformatf("wdata_i%0d_c%0d", s, k), 32'(bus_of(s)), 32'(d));
      if (k == sc + tc + 1)
        check($sformatf("rdata_i%0d", s), 32'(rdata_of(s)), 32'(exp_rd));
      if (k <= busy) tick();
    end
  endtask

  // ---------------- protocol invariants ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("rd_wr_overlap_a", 32'(rd_a & wr_a), 32'd0);
      check("strobe_without_en_a", 32'((rd_a | wr_a) & ~en_a), 32'd0);
      check("rd_wr_overlap_b", 32'(rd_b & wr_b), 32'd0);
      check("strobe_without_en_b", 32'((rd_b | wr_b) & ~en_b), 32'd0);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s, nxt_s, gap;
    logic w, hold;
    logic [7:0] a;
    logic [1:0] be;
    logic [15:0] d;

    rst = 1'b1;
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
      ref_mem[0][i] = '0;
      ref_mem[1][i] = '0;
    end
    last_rd[0] = '0;
    last_rd[1] = '0;

    // Reset state
    repeat (3) tick();
    check("reset_ctl_a", 32'(ctl_of(0)), 32'd0);
    check("reset_ctl_b", 32'(ctl_of(1)), 32'd0);
    check("reset_addr_be_a", 32'(ab_of(0)), 32'd0);
    check("reset_rdata_a", 32'(rdata_a), 32'd0);
    check("reset_state_a", 32'(st_a), 32'(ST_IDLE));
    rst = 1'b0;
    tick();
    check("ready_after_reset_a", 32'(ready_a), 32'd1);
    check("ready_after_reset_b", 32'(ready_b), 32'd1);

    // Directed write then read-back
    run_txn(0, 1'b1, 8'h05, 2'b11, 16'hBEEF, 1'b0);
    check("registers_hold_beef", 32'(mem_a[5]), 32'h0000BEEF);
    run_txn(0, 1'b0, 8'h05, 2'b11, 16'h0000, 1'b0);
    check("read_beef", 32'(rdata_a), 32'h0000BEEF);

    // Partial byte write
    run_txn(0, 1'b1, 8'h05, 2'b01, 16'hAA55, 1'b0);
    run_txn(0, 1'b0, 8'h05, 2'b11, 16'h0000, 1'b0);
    check("read_be55", 32'(rdata_a), 32'h0000BE55);

    // Back-to-back writes with valid held high
    run_txn(0, 1'b1, 8'h06, 2'b11, 16'h1234, 1'b1);
    run_txn(0, 1'b1, 8'h07, 2'b10, 16'h5678, 1'b0);

    // Zero byte enables still run a full bus cycle
    run_txn(0, 1'b1, 8'h08, 2'b00, 16'hFFFF, 1'b0);
    check("be0_no_change", 32'(mem_a[8]), 32'd0);

    // Reset during the second cycle of a write (scratch address)
    req_write = 1'b1;
    req_addr  = 8'h7F;
    req_be    = 2'b11;
    req_wdata = 16'h1111;
    req_valid_a = 1'b1;
    tick();
    req_valid_a = 1'b0;
    tick();
    check("abort_c2_ctl", 32'(ctl_of(0)), 32'(6'b101100));
    rst = 1'b1;
    tick();
    check("abort_c3_ctl", 32'(ctl_of(0)), 32'd0);
    check("abort_c3_addr_be", 32'(ab_of(0)), 32'd0);
    check("abort_c3_state", 32'(st_a), 32'(ST_IDLE));
    check("abort_c3_rdata", 32'(rdata_a), 32'd0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    rst = 1'b0;
    tick();
    check("abort_c4_ctl", 32'(ctl_of(0)), 32'(6'b000001));

    // Timing sweep instance
    run_txn(1, 1'b1, 8'h21, 2'b11, 16'hC0DE, 1'b0);
    run_txn(1, 1'b0, 8'h21, 2'b11, 16'h0000, 1'b0);
    check("sweep_read", 32'(rdata_b), 32'h0000C0DE);

    // Randomized traffic on both instances
    for (int i = 0; i < 48; i++) begin
      s     = (i % 4 == 3) ? 1 : 0;
      nxt_s = ((i + 1) % 4 == 3) ? 1 : 0;
      w     = 1'($urandom_range(0, 1));
      a     = 8'($urandom_range(0, 15));
      be    = 2'($urandom_range(0, 3));
      d     = 16'($urandom);
      hold  = 1'($urandom_range(0, 1));
      gap   = int'($urandom_range(0, 2));
      run_txn(s, w, a, be, d, hold);
      if (!hold || gap > 0 || nxt_s != s) set_valid(s, 1'b0);
      repeat (gap) tick();
    end
    set_valid(0, 1'b0);
    set_valid(1, 1'b0);
    tick();

    // Final register contents against the model
    for (int i = 0; i < 16; i++) begin
      check($sformatf("final_mem_a_%0d", i), 32'(mem_a[i]), 32'(ref_mem[0][i]));
      check($sformatf("final_mem_b_%0d", i), 32'(mem_b[i]), 32'(ref_mem[1][i]));
    end
    check("final_mem_b_21", 32'(mem_b[8'h21]), 32'(ref_mem[1][8'h21]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
